// File: rtl/adc_align_pkg.sv
// Shared types and constants for the ADC frame aligner: FSM state encoding and default FR words.
package adc_align_pkg;

    typedef enum logic [2:0] {
        StSettle,
        StCheck,
        StSlip,
        StWait,
        StLocked,
        StError
    } align_state_e;

    // Default frame-clock words seen on a correctly aligned FR lane.
    localparam logic [7:0] FrPattern1Lane = 8'hFF;
    localparam logic [7:0] FrPattern2Lane = 8'hF0;

endpackage

// File: rtl/adc_lane_interleave.sv
// Combinational lane-to-sample bit interleaver for one ADC channel.
module adc_lane_interleave #(
    parameter int unsigned LANES = 2,
    parameter int unsigned SER_W = 8,
    parameter bit          SWAP  = 1'b0
) (
    input  logic [LANES*SER_W-1:0] lanes,
    output logic [LANES*SER_W-1:0] sample
);

    generate
        if (LANES == 2) begin : g_two_lane
            logic [SER_W-1:0] lane_a;
            logic [SER_W-1:0] lane_b;

            // Lane A carries the odd sample bits, lane B the even ones.
            assign lane_a = SWAP ? lanes[SER_W +: SER_W] : lanes[0 +: SER_W];
            assign lane_b = SWAP ? lanes[0 +: SER_W] : lanes[SER_W +: SER_W];

            for (genvar k = 0; k < SER_W; k++) begin : g_bit
                assign sample[2*k+1] = lane_a[k];
                assign sample[2*k]   = lane_b[k];
            end
        end else begin : g_one_lane
            assign sample = lanes;
        end
    endgenerate

endmodule

// File: rtl/adc_frame_aligner.sv
// Bitslip-driven frame aligner and sample assembler for multi-lane serial ADCs.
module adc_frame_aligner
    import adc_align_pkg::*;
#(
    parameter int unsigned       NUM_CH      = 2,
    parameter int unsigned       LANES       = 2,
    parameter int unsigned       SER_W       = 8,
    parameter logic [SER_W-1:0]  FR_PATTERN  = FrPattern2Lane,
    parameter int unsigned       SETTLE_CYC  = 16,
    parameter int unsigned       SLIP_WAIT   = 4,
    parameter int unsigned       LOCK_CHECKS = 4,
    parameter logic [NUM_CH-1:0] LANE_SWAP   = 'b10
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            align_req_in,
    input  logic [SER_W-1:0]                fr_word_in,
    input  logic [NUM_CH*LANES*SER_W-1:0]   data_word_in,
    output logic                            bitslip_out,
    output logic [NUM_CH*LANES*SER_W-1:0]   adc_out,
    output logic                            adc_valid_out,
    output logic                            locked_out,
    output logic                            align_err_out,
    output logic [$clog2(SER_W):0]          slip_count_out
);

    localparam int unsigned SAMPLE_W = LANES * SER_W;
    localparam int unsigned CntMax   = (SETTLE_CYC > SLIP_WAIT) ? SETTLE_CYC : SLIP_WAIT;
    localparam int unsigned CntW     = $clog2(CntMax + 1);
    localparam int unsigned MatchW   = $clog2(LOCK_CHECKS + 1);
    localparam int unsigned SlipW    = $clog2(SER_W) + 1;

    localparam logic [CntW-1:0]   SettleLast = CntW'(SETTLE_CYC - 1);
    localparam logic [CntW-1:0]   WaitLast   = CntW'(SLIP_WAIT - 1);
    localparam logic [MatchW-1:0] LockLast   = MatchW'(LOCK_CHECKS - 1);
    localparam logic [SlipW-1:0]  SlipMax    = SlipW'(SER_W);

    align_state_e                state_q;
    logic [CntW-1:0]             cnt_q;
    logic [MatchW-1:0]           match_q;
    logic                        miss_q;
    logic [SlipW-1:0]            slip_q;
    logic                        bitslip_q;
    logic                        locked_q;
    logic                        valid_q;
    logic                        err_q;
    logic [NUM_CH*SAMPLE_W-1:0]  adc_q;
    logic [NUM_CH*SAMPLE_W-1:0]  sample_next;
    logic                        fr_match;

    assign fr_match = (fr_word_in == FR_PATTERN);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        adc_lane_interleave #(
            .LANES (LANES),
            .SER_W (SER_W),
            .SWAP  (LANE_SWAP[c])
        ) u_interleave (
            .lanes  (data_word_in[c*SAMPLE_W +: SAMPLE_W]),
            .sample (sample_next[c*SAMPLE_W +: SAMPLE_W])
        );
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= StSettle;
            cnt_q     <= '0;
            match_q   <= '0;
            miss_q    <= 1'b0;
            slip_q    <= '0;
            bitslip_q <= 1'b0;
            locked_q  <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            adc_q     <= '0;
        end else if (align_req_in) begin
            state_q   <= StSettle;
            cnt_q     <= '0;
            match_q   <= '0;
            miss_q    <= 1'b0;
            slip_q    <= '0;
            bitslip_q <= 1'b0;
            locked_q  <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            bitslip_q <= 1'b0;
            locked_q  <= 1'b0;
            valid_q   <= 1'b0;
            unique case (state_q)
                StSettle: begin
                    if (cnt_q == SettleLast) begin
                        cnt_q   <= '0;
                        state_q <= StCheck;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StCheck: begin
                    if (fr_match) begin
                        if (match_q == LockLast) begin
                            match_q <= '0;
                            miss_q  <= 1'b0;
                            state_q <= StLocked;
                        end else begin
                            match_q <= match_q + MatchW'(1);
                        end
                    end else begin
                        match_q <= '0;
                        if (slip_q == SlipMax) begin
                            err_q   <= 1'b1;
                            state_q <= StError;
                        end else begin
                            bitslip_q <= 1'b1;
                            state_q   <= StSlip;
                        end
                    end
                end
                StSlip: begin
                    if (slip_q != SlipMax) begin
                        slip_q <= slip_q + SlipW'(1);
                    end
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (cnt_q == WaitLast) begin
                        cnt_q   <= '0;
                        state_q <= StCheck;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StLocked: begin
                    // One stray FR miss is forgiven; a second in a row drops lock.
                    if (fr_match || !miss_q) begin
                        miss_q   <= !fr_match;
                        locked_q <= 1'b1;
                        valid_q  <= 1'b1;
                        adc_q    <= sample_next;
                    end else begin
                        miss_q  <= 1'b0;
                        slip_q  <= '0;
                        state_q <= StCheck;
                    end
                end
                StError: begin
                    state_q <= StError;
                end
                default: begin
                    state_q <= StSettle;
                end
            endcase
        end
    end

    assign bitslip_out    = bitslip_q;
    assign adc_out        = adc_q;
    assign adc_valid_out  = valid_q;
    assign locked_out     = locked_q;
    assign align_err_out  = err_q;
    assign slip_count_out = slip_q;

endmodule

// File: tb/tb_adc_frame_aligner.sv
// Self-checking bench for adc_frame_aligner with a rotating-ISERDES stand-in and sample model.
module tb_adc_frame_aligner;

    localparam int         SETTLE    = 16;
    localparam int         SLIPW     = 4;
    localparam int         CHECKS    = 4;
    localparam logic [1:0] SWAP_MASK = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        align_req;
    logic [7:0]  fr_word;
    logic [31:0] data_word;
    logic        bitslip;
    logic [31:0] adc;
    logic        adc_valid;
    logic        locked;
    logic        align_err;
    logic [3:0]  slip_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_total = 0;
    int pulse_base = 0;
    int pulse_at [64];
    int rot_start = 0;
    logic       fr_force = 1'b0;
    logic [7:0] fr_forced = 8'h00;

    typedef struct {
        logic [7:0]  l00, l01, l10, l11;
        logic [15:0] e0, e1;
    } vec_t;
    vec_t tbl [5];

    adc_frame_aligner #(
        .NUM_CH      (2),
        .LANES       (2),
        .SER_W       (8),
        .FR_PATTERN  (8'hF0),
        .SETTLE_CYC  (SETTLE),
        .SLIP_WAIT   (SLIPW),
        .LOCK_CHECKS (CHECKS),
        .LANE_SWAP   (SWAP_MASK)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .align_req_in   (align_req),
        .fr_word_in     (fr_word),
        .data_word_in   (data_word),
        .bitslip_out    (bitslip),
        .adc_out        (adc),
        .adc_valid_out  (adc_valid),
        .locked_out     (locked),
        .align_err_out  (align_err),
        .slip_count_out (slip_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rotl8(input logic [7:0] w, input int n);
        logic [7:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Reference sample: odd bits from lane A, even bits from lane B.
    function automatic logic [15:0] model_sample(input logic [7:0] l0, input logic [7:0] l1,
                                                 input bit swap);
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] s;
        a = swap ? l1 : l0;
        b = swap ? l0 : l1;
        for (int i = 0; i < 16; i++) s[i] = (i % 2 == 1) ? a[i/2] : b[i/2];
        return s;
    endfunction

    // ISERDES stand-in: each bitslip pulse rotates the FR word left by one bit.
    assign fr_word = fr_force ? fr_forced
                              : rotl8(8'hF0, (rot_start + pulse_total - pulse_base) % 8);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bitslip === 1'b1) begin
            pulse_at[pulse_total % 64] = cyc;
            pulse_total = pulse_total + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int start_rot);
        rst_n     = 1'b0;
        align_req = 1'b0;
        fr_force  = 1'b0;
        rot_start = start_rot;
        pulse_base = pulse_total;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_locked(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(posedge clk);
            #1;
            if (locked === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ok;
        int r;
        logic [31:0] held;
        logic [7:0]  w [4];

        tbl[0] = '{8'hDE, 8'h49, 8'h49, 8'hDE, 16'hB2E9, 16'hB2E9};
        tbl[1] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 16'hAAAA, 16'hAAAA};
        tbl[2] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 16'h5555, 16'h5555};
        tbl[3] = '{8'h0F, 8'h00, 8'h00, 8'h0F, 16'h00AA, 16'h00AA};
        tbl[4] = '{8'hF0, 8'hF0, 8'h00, 8'h00, 16'hFF00, 16'h0000};

        rst_n     = 1'b0;
        align_req = 1'b0;
        data_word = 32'h0;
        #1;
        check("reset_outputs", {27'h0, bitslip, adc_valid, locked, align_err, 1'b0},
              32'h0);
        check("reset_adc", adc, 32'h0);
        check("reset_slip_count", {28'h0, slip_count}, 32'h0);

        // Aligned start: lock with no slips.
        do_reset(0);
        wait_locked(100, n);
        check("aligned_lock_latency", n, SETTLE + CHECKS + 1);
        check("aligned_pulses", pulse_total - pulse_base, 0);
        check("aligned_slip_count", {28'h0, slip_count}, 32'd0);
        check("aligned_valid", {31'h0, adc_valid}, 32'd1);

        // Table of lane patterns applied while locked.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            data_word = {tbl[i].l11, tbl[i].l10, tbl[i].l01, tbl[i].l00};
            @(posedge clk);
            #1;
            check($sformatf("table%0d_ch0", i), {16'h0, adc[15:0]}, {16'h0, tbl[i].e0});
            check($sformatf("table%0d_ch1", i), {16'h0, adc[31:16]}, {16'h0, tbl[i].e1});
            check($sformatf("table%0d_valid", i), {31'h0, adc_valid}, 32'd1);
        end

        // Random lane words against the model.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) w[j] = 8'($urandom);
            data_word = {w[3], w[2], w[1], w[0]};
            @(posedge clk);
            #1;
            check("rand_ch0", {16'h0, adc[15:0]}, {16'h0, model_sample(w[0], w[1], SWAP_MASK[0])});
            check("rand_ch1", {16'h0, adc[31:16]},
                  {16'h0, model_sample(w[2], w[3], SWAP_MASK[1])});
        end

        // Single-cycle FR glitch is tolerated.
        pulse_base = pulse_total;
        @(negedge clk);
        fr_force  = 1'b1;
        fr_forced = 8'h00;
        @(negedge clk);
        fr_force = 1'b0;
        ok = 1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (locked !== 1'b1 || adc_valid !== 1'b1) ok = 0;
        end
        check("glitch1_stays_locked", ok, 1);

        // Two-cycle glitch drops lock, then re-check re-locks without slipping.
        @(negedge clk);
        fr_force = 1'b1;
        @(negedge clk);
        @(negedge clk);
        fr_force = 1'b0;
        check("glitch2_unlocked", {31'h0, locked}, 32'd0);
        check("glitch2_invalid", {31'h0, adc_valid}, 32'd0);
        held = adc;
        data_word = ~held;
        @(posedge clk);
        #1;
        check("unlocked_adc_holds", adc, held);
        wait_locked(50, n);
        check("relock_latency", n, CHECKS);
        check("relock_pulses", pulse_total - pulse_base, 0);
        check("relock_slip_count", {28'h0, slip_count}, 32'd0);

        // Start rotated by 3: three evenly spaced single-cycle slips.
        do_reset(5);
        wait_locked(300, n);
        check("rot3_lock_latency", n, SETTLE + 3 * (SLIPW + 2) + CHECKS + 1);
        check("rot3_pulses", pulse_total - pulse_base, 3);
        check("rot3_slip_count", {28'h0, slip_count}, 32'd3);
        for (int k = 0; k < 2; k++)
            check("rot3_pulse_gap",
                  pulse_at[(pulse_base + k + 1) % 64] - pulse_at[(pulse_base + k) % 64],
                  SLIPW + 2);

        // Random starting rotations.
        for (int t = 0; t < 4; t++) begin
            r = int'($urandom_range(0, 7));
            do_reset(r);
            wait_locked(300, n);
            check("randrot_locked", {31'h0, locked}, 32'd1);
            check("randrot_pulses", pulse_total - pulse_base, (8 - r) % 8);
            check("randrot_slip_count", {28'h0, slip_count}, (8 - r) % 8);
        end

        // Unalignable FR: eight slips, then a held error with no further slips.
        do_reset(0);
        fr_force  = 1'b1;
        fr_forced = 8'h00;
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if (align_err === 1'b1) begin
                n = i;
                break;
            end
        end
        check("err_raised", {31'h0, align_err}, 32'd1);
        check("err_pulses", pulse_total - pulse_base, 8);
        check("err_slip_count", {28'h0, slip_count}, 32'd8);
        ok = 1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bitslip !== 1'b0 || align_err !== 1'b1) ok = 0;
        end
        check("err_held_no_slip", ok, 1);
        check("err_no_more_pulses", pulse_total - pulse_base, 8);
        @(negedge clk);
        fr_force  = 1'b0;
        align_req = 1'b1;
        @(negedge clk);
        align_req = 1'b0;
        check("req_clears_err", {31'h0, align_err}, 32'd0);
        check("req_clears_slip_count", {28'h0, slip_count}, 32'd0);
        wait_locked(100, n);
        check("req_restart_latency", n, SETTLE + CHECKS + 1);

        // Reset asynchronously while a bitslip pulse is high.
        do_reset(5);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bitslip === 1'b1) begin
                ok = 1;
                break;
            end
        end
        check("saw_bitslip", ok, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_bitslip", {31'h0, bitslip}, 32'd0);
        check("async_reset_outputs",
              {24'h0, slip_count, adc_valid, locked, align_err, bitslip}, 32'h0);
        check("async_reset_adc", adc, 32'h0);

        // align_req coinciding with the final lock match wins.
        do_reset(0);
        repeat (SETTLE + CHECKS - 1) @(posedge clk);
        @(negedge clk);
        align_req = 1'b1;
        @(posedge clk);
        #1;
        check("req_at_lock_edge", {31'h0, locked}, 32'd0);
        @(negedge clk);
        align_req = 1'b0;
        ok = 1;
        repeat (SETTLE + CHECKS) begin
            @(posedge clk);
            #1;
            if (locked !== 1'b0) ok = 0;
        end
        check("req_at_lock_stays_unlocked", ok, 1);
        @(posedge clk);
        #1;
        check("req_at_lock_relocks", {31'h0, locked}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
